// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: maps note-on events onto NUM_VOICES voices, stealing the oldest when full.
// Optional sustain pedal support is enabled by defining VOICE_ALLOC_SUSTAIN_EN.
module voice_allocator #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned KEY_W      = 4,
  parameter int unsigned AGE_W      = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        note_on_valid_i,
  output logic                        note_on_ready_o,
  input  logic [KEY_W-1:0]            note_on_key_i,
  input  logic                        note_off_valid_i,
  input  logic [KEY_W-1:0]            note_off_key_i,
`ifdef VOICE_ALLOC_SUSTAIN_EN
  input  logic                        sustain_i,
`endif
  output logic [NUM_VOICES-1:0]       voice_active_o,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key_o,
  output logic [NUM_VOICES-1:0]       voice_trig_o,
  output logic                        steal_o
);

  localparam int unsigned TGT_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_SEARCH = 2'b01;
  localparam logic [1:0] ST_COMMIT = 2'b10;

  logic [1:0]                       state_q, state_d;
  logic                             ready_q, ready_d;
  logic [KEY_W-1:0]                 key_q, key_d;
  logic [TGT_W-1:0]                 tgt_q, tgt_d;
  logic                             steal_pend_q, steal_pend_d;
  logic [NUM_VOICES-1:0]            active_q, active_d;
  logic [NUM_VOICES-1:0][KEY_W-1:0] keys_q, keys_d;
  logic [NUM_VOICES-1:0][AGE_W-1:0] age_q, age_d;
  logic [NUM_VOICES-1:0]            trig_q, trig_d;
  logic                             steal_q, steal_d;
`ifdef VOICE_ALLOC_SUSTAIN_EN
  logic [NUM_VOICES-1:0]            held_q, held_d;
`endif

  logic                             sel_found;
  logic [TGT_W-1:0]                 sel_tgt;
  logic                             sel_steal;
  logic [AGE_W-1:0]                 best_age;

  // Target choice: retrigger matching key, else lowest free voice, else oldest voice.
  always_comb begin
    sel_found = 1'b0;
    sel_tgt   = '0;
    sel_steal = 1'b0;
    best_age  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!sel_found && active_q[i] && (keys_q[i] == key_q)) begin
        sel_found = 1'b1;
        sel_tgt   = TGT_W'(i);
      end
    end
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!sel_found && !active_q[i]) begin
        sel_found = 1'b1;
        sel_tgt   = TGT_W'(i);
      end
    end
    if (!sel_found) begin
      sel_steal = 1'b1;
      best_age  = age_q[0];
      for (int i = 1; i < NUM_VOICES; i++) begin
        if (age_q[i] > best_age) begin
          best_age = age_q[i];
          sel_tgt  = TGT_W'(i);
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    tgt_d        = tgt_q;
    steal_pend_d = steal_pend_q;
    active_d     = active_q;
    keys_d       = keys_q;
    age_d        = age_q;
    trig_d       = '0;
    steal_d      = 1'b0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
    held_d       = held_q;
`endif

    // Note-off is applied before any commit so a same-edge commit wins.
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (note_off_valid_i && active_q[i] && (keys_q[i] == note_off_key_i)) begin
`ifdef VOICE_ALLOC_SUSTAIN_EN
        if (sustain_i) begin
          held_d[i] = 1'b1;
        end else begin
          active_d[i] = 1'b0;
          age_d[i]    = '0;
          held_d[i]   = 1'b0;
        end
`else
        active_d[i] = 1'b0;
        age_d[i]    = '0;
`endif
      end
`ifdef VOICE_ALLOC_SUSTAIN_EN
      if (held_q[i] && !sustain_i) begin
        active_d[i] = 1'b0;
        age_d[i]    = '0;
        held_d[i]   = 1'b0;
      end
`endif
    end

    case (state_q)
      ST_IDLE: begin
        if (note_on_valid_i) begin
          key_d   = note_on_key_i;
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        tgt_d        = sel_tgt;
        steal_pend_d = sel_steal;
        state_d      = ST_COMMIT;
      end
      ST_COMMIT: begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (TGT_W'(i) == tgt_q) begin
            active_d[i] = 1'b1;
            keys_d[i]   = key_q;
            age_d[i]    = '0;
            trig_d[i]   = 1'b1;
`ifdef VOICE_ALLOC_SUSTAIN_EN
            held_d[i]   = 1'b0;
`endif
          end else if (active_d[i] && (age_d[i] != AGE_MAX)) begin
            age_d[i] = age_d[i] + AGE_W'(1);
          end
        end
        steal_d = steal_pend_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b1;
      key_q        <= '0;
      tgt_q        <= '0;
      steal_pend_q <= 1'b0;
      active_q     <= '0;
      keys_q       <= '0;
      age_q        <= '0;
      trig_q       <= '0;
      steal_q      <= 1'b0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
      held_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      key_q        <= key_d;
      tgt_q        <= tgt_d;
      steal_pend_q <= steal_pend_d;
      active_q     <= active_d;
      keys_q       <= keys_d;
      age_q        <= age_d;
      trig_q       <= trig_d;
      steal_q      <= steal_d;
`ifdef VOICE_ALLOC_SUSTAIN_EN
      held_q       <= held_d;
`endif
    end
  end

  assign note_on_ready_o = ready_q;
  assign voice_active_o  = active_q;
  assign voice_key_o     = keys_q;
  assign voice_trig_o    = trig_q;
  assign steal_o         = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: a behavioural voice model predicts each commit.
module tb_voice_allocator;
  localparam int unsigned NV = 4;
  localparam int unsigned KW = 4;
  localparam int unsigned AW = 4;
  localparam int AGE_SAT = (1 << AW) - 1;

  logic              clk_i;
  logic              rst_i;
  logic              note_on_valid_i;
  logic              note_on_ready_o;
  logic [KW-1:0]     note_on_key_i;
  logic              note_off_valid_i;
  logic [KW-1:0]     note_off_key_i;
`ifdef VOICE_ALLOC_SUSTAIN_EN
  logic              sustain_i;
`endif
  logic [NV-1:0]     voice_active_o;
  logic [NV*KW-1:0]  voice_key_o;
  logic [NV-1:0]     voice_trig_o;
  logic              steal_o;

  typedef struct packed {
    logic [NV-1:0]    trig;
    logic             steal;
    logic [NV-1:0]    active;
    logic [NV*KW-1:0] keys;
  } exp_t;

  exp_t          sb_q[$];
  logic          m_act [NV];
  logic [KW-1:0] m_key [NV];
  int            m_age [NV];
  int            checks = 0;
  int            errors = 0;

  voice_allocator #(.NUM_VOICES(NV), .KEY_W(KW), .AGE_W(AW)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .note_on_valid_i  (note_on_valid_i),
    .note_on_ready_o  (note_on_ready_o),
    .note_on_key_i    (note_on_key_i),
    .note_off_valid_i (note_off_valid_i),
    .note_off_key_i   (note_off_key_i),
`ifdef VOICE_ALLOC_SUSTAIN_EN
    .sustain_i        (sustain_i),
`endif
    .voice_active_o   (voice_active_o),
    .voice_key_o      (voice_key_o),
    .voice_trig_o     (voice_trig_o),
    .steal_o          (steal_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [NV-1:0] model_active();
    logic [NV-1:0] a;
    for (int i = 0; i < NV; i++) a[i] = m_act[i];
    return a;
  endfunction

  function automatic logic [NV*KW-1:0] model_keys();
    logic [NV*KW-1:0] k;
    for (int i = 0; i < NV; i++) k[i*KW +: KW] = m_key[i];
    return k;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_act[i] = 1'b0;
      m_key[i] = '0;
      m_age[i] = 0;
    end
    sb_q.delete();
  endtask

  task automatic model_off(input logic [KW-1:0] key);
    for (int i = 0; i < NV; i++) begin
      if (m_act[i] && m_key[i] == key) begin
        m_act[i] = 1'b0;
        m_age[i] = 0;
      end
    end
  endtask

  task automatic model_commit(input logic [KW-1:0] key, output exp_t e);
    int   tgt = -1;
    logic st  = 1'b0;
    for (int i = 0; i < NV; i++) if (tgt < 0 && m_act[i] && m_key[i] == key) tgt = i;
    for (int i = 0; i < NV; i++) if (tgt < 0 && !m_act[i]) tgt = i;
    if (tgt < 0) begin
      st  = 1'b1;
      tgt = 0;
      for (int i = 1; i < NV; i++) if (m_age[i] > m_age[tgt]) tgt = i;
    end
    for (int i = 0; i < NV; i++) begin
      if (i == tgt) begin
        m_act[i] = 1'b1;
        m_key[i] = key;
        m_age[i] = 0;
      end else if (m_act[i] && m_age[i] < AGE_SAT) begin
        m_age[i] = m_age[i] + 1;
      end
    end
    e.trig      = '0;
    e.trig[tgt] = 1'b1;
    e.steal     = st;
    e.active    = model_active();
    e.keys      = model_keys();
  endtask

  task automatic do_reset();
    rst_i            = 1'b0;
    note_on_valid_i  = 1'b0;
    note_on_key_i    = '0;
    note_off_valid_i = 1'b0;
    note_off_key_i   = '0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
    sustain_i        = 1'b0;
`endif
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    model_reset();
  endtask

  // Entered and left at a negedge; the accept edge is the next posedge.
  task automatic note_on(input logic [KW-1:0] key);
    int   n = 0;
    exp_t e;
    while (!note_on_ready_o && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (note_on_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: ready=%b required 1", note_on_ready_o);
    end
    note_on_valid_i = 1'b1;
    note_on_key_i   = key;
    model_commit(key, e);
    sb_q.push_back(e);
    @(negedge clk_i);
    note_on_valid_i = 1'b0;
    checks++;
    if (note_on_ready_o !== 1'b0 || voice_trig_o !== '0) begin
      errors++;
      $display("FAIL busy_after_accept: ready=%b trig=%b required ready=0 trig=0000",
               note_on_ready_o, voice_trig_o);
    end
  endtask

  task automatic wait_commit(input logic off_at_commit, input logic [KW-1:0] off_key);
    exp_t e;
    int   lat  = 0;
    logic seen = 1'b0;
    while (!seen && lat < 6) begin
      @(negedge clk_i);
      lat++;
      note_off_valid_i = 1'b0;
      if (voice_trig_o !== '0) seen = 1'b1;
      else if (off_at_commit && lat == 1) begin
        note_off_valid_i = 1'b1;
        note_off_key_i   = off_key;
      end
    end
    checks++;
    if (!seen || lat != 2) begin
      errors++;
      $display("FAIL commit_latency: seen=%b cycles=%0d required seen=1 cycles=2", seen, lat);
    end
    if (seen) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_trig: trig=%b with no pending note", voice_trig_o);
      end else begin
        e = sb_q.pop_front();
        if (voice_trig_o !== e.trig || steal_o !== e.steal ||
            voice_active_o !== e.active || voice_key_o !== e.keys) begin
          errors++;
          $display("FAIL commit: trig=%b steal=%b active=%b keys=%h required trig=%b steal=%b active=%b keys=%h",
                   voice_trig_o, steal_o, voice_active_o, voice_key_o,
                   e.trig, e.steal, e.active, e.keys);
        end
      end
    end
  endtask

  task automatic check_idle_state(input string name);
    checks++;
    if (voice_active_o !== model_active() || voice_key_o !== model_keys() ||
        voice_trig_o !== '0 || steal_o !== 1'b0) begin
      errors++;
      $display("FAIL %s: active=%b keys=%h trig=%b steal=%b required active=%b keys=%h trig=0000 steal=0",
               name, voice_active_o, voice_key_o, voice_trig_o, steal_o,
               model_active(), model_keys());
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (voice_active_o !== '0 || voice_key_o !== '0 || voice_trig_o !== '0 ||
        steal_o !== 1'b0 || note_on_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: active=%b keys=%h trig=%b steal=%b ready=%b required 0/0/0/0/1",
               voice_active_o, voice_key_o, voice_trig_o, steal_o, note_on_ready_o);
    end
  endtask

  task automatic test_single_note();
    note_on(4'd3);
    wait_commit(1'b0, '0);
    @(negedge clk_i);
    check_idle_state("trig_single_pulse");
    // Note-off clears the voice but its key output is held
    note_off_valid_i = 1'b1;
    note_off_key_i   = 4'd3;
    model_off(4'd3);
    @(negedge clk_i);
    note_off_valid_i = 1'b0;
    check_idle_state("note_off_clear");
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      note_on(KW'(k));
      wait_commit(1'b0, '0);
    end
    note_on(4'd9);
    wait_commit(1'b0, '0);
    note_on(4'd10);
    wait_commit(1'b0, '0);
    note_on(4'd3);
    wait_commit(1'b0, '0);
    note_off_valid_i = 1'b1;
    note_off_key_i   = 4'd15;
    model_off(4'd15);
    @(negedge clk_i);
    note_off_valid_i = 1'b0;
    check_idle_state("note_off_unmatched");
  endtask

  task automatic test_retrigger();
    do_reset();
    note_on(4'd1);
    wait_commit(1'b0, '0);
    note_on(4'd2);
    wait_commit(1'b0, '0);
    note_on(4'd2);
    wait_commit(1'b0, '0);
    note_on(4'd2);
    wait_commit(1'b1, 4'd2);
    @(negedge clk_i);
    check_idle_state("off_same_edge_as_commit");
  endtask

  task automatic test_age_saturation();
    do_reset();
    note_on(4'd1);
    wait_commit(1'b0, '0);
    note_on(4'd2);
    wait_commit(1'b0, '0);
    for (int r = 0; r < 13; r++) begin
      note_on(4'd2);
      wait_commit(1'b0, '0);
    end
    note_on(4'd3);
    wait_commit(1'b0, '0);
    note_on(4'd4);
    wait_commit(1'b0, '0);
    note_on(4'd5);
    wait_commit(1'b0, '0);
  endtask

  task automatic test_reset_mid_search();
    do_reset();
    note_on(4'd7);
    rst_i = 1'b0;
    #1;
    checks++;
    if (voice_active_o !== '0 || voice_key_o !== '0 || voice_trig_o !== '0 ||
        steal_o !== 1'b0 || note_on_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_search: active=%b keys=%h trig=%b steal=%b ready=%b required 0/0/0/0/1",
               voice_active_o, voice_key_o, voice_trig_o, steal_o, note_on_ready_o);
    end
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      check_idle_state("no_trig_after_reset");
    end
    note_on(4'd5);
    wait_commit(1'b0, '0);
  endtask

`ifdef VOICE_ALLOC_SUSTAIN_EN
  task automatic test_sustain();
    do_reset();
    sustain_i = 1'b1;
    note_on(4'd5);
    wait_commit(1'b0, '0);
    note_off_valid_i = 1'b1;
    note_off_key_i   = 4'd5;
    @(negedge clk_i);
    note_off_valid_i = 1'b0;
    @(negedge clk_i);
    check_idle_state("sustain_hold");
    sustain_i = 1'b0;
    model_off(4'd5);
    @(negedge clk_i);
    check_idle_state("sustain_release");
  endtask
`endif

  initial begin
    test_reset();
    test_single_note();
    test_back_to_back();
    test_retrigger();
    test_age_saturation();
    test_reset_mid_search();
`ifdef VOICE_ALLOC_SUSTAIN_EN
    test_sustain();
`endif
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
